meta_flush_ctrl: RTL and testbench

//  Owns the single port of one cache metadata flop array (valid/dirty bits per set, comb read).

---
 rtl/meta_flush_ctrl.sv | 158 +++++++++++++++
 tb/tb_meta_flush_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/meta_flush_ctrl.sv
// meta_flush_ctrl
//   Owns the single port of a cache metadata flop array (valid/dirty per set,
//   combinational read). In IDLE it muxes the controller's lookup read and
//   update write onto the port. On flush_req it sweeps every set. Each
//   valid+dirty set is handed to the writeback path, and each set is then
//   cleared.
// Ports
//   clk0, rst0            clock, synchronous active-high reset
//   rd_addr/rd_data/rd_ok lookup read (rd_data is combinational from arr_dout0)
//   wr_valid/wr_addr/wr_din/wr_ready  update write (accepted on valid & ready)
//   flush_req/busy/flush_done         flush control and status
//   wb_req/wb_set/wb_ack              writeback handshake for one set
//   arr_csb0/arr_web0/arr_addr0/arr_din0/arr_dout0  metadata array port
module meta_flush_ctrl #(
  parameter int unsigned s_index   = 4,
  parameter int unsigned width     = 2,
  parameter int unsigned valid_bit = 0,
  parameter int unsigned dirty_bit = 1
) (
  input  logic               clk0,
  input  logic               rst0,
  input  logic [s_index-1:0] rd_addr,
  output logic [width-1:0]   rd_data,
  output logic               rd_ok,
  input  logic               wr_valid,
  input  logic [s_index-1:0] wr_addr,
  input  logic [width-1:0]   wr_din,
  output logic               wr_ready,
  input  logic               flush_req,
  output logic               busy,
  output logic               flush_done,
  output logic               wb_req,
  output logic [s_index-1:0] wb_set,
  input  logic               wb_ack,
  output logic               arr_csb0,
  output logic               arr_web0,
  output logic [s_index-1:0] arr_addr0,
  output logic [width-1:0]   arr_din0,
  input  logic [width-1:0]   arr_dout0
);

  localparam logic [s_index-1:0] last_idx = '1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_WB_WAIT,
    ST_CLEAR,
    ST_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [s_index-1:0] idx_q, idx_d;

  // Lookup data is the raw array read; rd_ok qualifies it.
  assign rd_data = arr_dout0;

  // State and sweep-index registers.
  always_ff @(posedge clk0) begin
    if (rst0) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state and port mux.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    busy       = 1'b0;
    flush_done = 1'b0;
    wb_req     = 1'b0;
    wb_set     = '0;
    wr_ready   = 1'b0;
    rd_ok      = 1'b0;
    arr_csb0   = 1'b1;
    arr_web0   = 1'b1;
    arr_addr0  = '0;
    arr_din0   = '0;

    unique case (state_q)
      ST_IDLE: begin
        wr_ready = 1'b1;
        arr_csb0 = 1'b0;
        if (wr_valid) begin
          arr_web0  = 1'b0;
          arr_addr0 = wr_addr;
          arr_din0  = wr_din;
        end else begin
          arr_addr0 = rd_addr;
          rd_ok     = 1'b1;
        end
        // A write in the same cycle still lands before the sweep reads it.
        if (flush_req) begin
          state_d = ST_CHECK;
          idx_d   = '0;
        end
      end
      ST_CHECK: begin
        busy      = 1'b1;
        arr_csb0  = 1'b0;
        arr_addr0 = idx_q;
        if (arr_dout0[valid_bit] && arr_dout0[dirty_bit]) begin
          state_d = ST_WB_WAIT;
        end else begin
          state_d = ST_CLEAR;
        end
      end
      ST_WB_WAIT: begin
        busy   = 1'b1;
        wb_req = 1'b1;
        wb_set = idx_q;
        if (wb_ack) begin
          state_d = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        busy      = 1'b1;
        arr_csb0  = 1'b0;
        arr_web0  = 1'b0;
        arr_addr0 = idx_q;
        arr_din0  = '0;
        if (idx_q == last_idx) begin
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + s_index'(1);
          state_d = ST_CHECK;
        end
      end
      ST_DONE: begin
        busy       = 1'b1;
        flush_done = 1'b1;
        state_d    = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Reset holds every output quiet, and keeps the array deselected.
    if (rst0) begin
      busy       = 1'b0;
      flush_done = 1'b0;
      wb_req     = 1'b0;
      wb_set     = '0;
      wr_ready   = 1'b0;
      rd_ok      = 1'b0;
      arr_csb0   = 1'b1;
      arr_web0   = 1'b1;
      arr_addr0  = '0;
      arr_din0   = '0;
    end
  end

endmodule

// File: tb/tb_meta_flush_ctrl.sv
// tb_meta_flush_ctrl
//   Bench for meta_flush_ctrl. It models the metadata flop array, drives
//   randomized lookups, writes and flushes, and checks the DUT against a
//   set-level model: expected contents, expected writeback order and
//   expected sweep length.
module tb_meta_flush_ctrl;

  localparam int unsigned num_sets = 16;

  logic       clk = 1'b0;
  logic       rst0;
  logic [3:0] rd_addr;
  logic [1:0] rd_data;
  logic       rd_ok;
  logic       wr_valid;
  logic [3:0] wr_addr;
  logic [1:0] wr_din;
  logic       wr_ready;
  logic       flush_req;
  logic       busy;
  logic       flush_done;
  logic       wb_req;
  logic [3:0] wb_set;
  logic       wb_ack;
  logic       arr_csb0;
  logic       arr_web0;
  logic [3:0] arr_addr0;
  logic [1:0] arr_din0;
  logic [1:0] arr_dout0;

  logic [1:0] arr_mem [num_sets];
  logic [1:0] ref_mem [num_sets];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  meta_flush_ctrl #(
    .s_index  (4),
    .width    (2),
    .valid_bit(0),
    .dirty_bit(1)
  ) dut (
    .clk0      (clk),
    .rst0      (rst0),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_ok     (rd_ok),
    .wr_valid  (wr_valid),
    .wr_addr   (wr_addr),
    .wr_din    (wr_din),
    .wr_ready  (wr_ready),
    .flush_req (flush_req),
    .busy      (busy),
    .flush_done(flush_done),
    .wb_req    (wb_req),
    .wb_set    (wb_set),
    .wb_ack    (wb_ack),
    .arr_csb0  (arr_csb0),
    .arr_web0  (arr_web0),
    .arr_addr0 (arr_addr0),
    .arr_din0  (arr_din0),
    .arr_dout0 (arr_dout0)
  );

  // Flop array with a combinational read port.
  assign arr_dout0 = arr_mem[arr_addr0];
  always @(posedge clk) begin
    if (!arr_csb0 && !arr_web0) arr_mem[arr_addr0] <= arr_din0;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_write(input logic [3:0] a, input logic [1:0] v);
    @(negedge clk);
    flush_req = 1'b0;
    wb_ack    = 1'b0;
    wr_valid  = 1'b1;
    wr_addr   = a;
    wr_din    = v;
    rd_addr   = 4'($urandom);
    #1;
    check_eq("wr_ready", wr_ready, 1);
    check_eq("wr_rd_ok", rd_ok, 0);
    check_eq("wr_csb", arr_csb0, 0);
    check_eq("wr_web", arr_web0, 0);
    check_eq("wr_addr", arr_addr0, a);
    check_eq("wr_din", arr_din0, v);
    ref_mem[a] = v;
  endtask

  task automatic idle_read(input logic [3:0] a);
    @(negedge clk);
    flush_req = 1'b0;
    wb_ack    = 1'b0;
    wr_valid  = 1'b0;
    rd_addr   = a;
    #1;
    check_eq("rd_ok", rd_ok, 1);
    check_eq("rd_csb", arr_csb0, 0);
    check_eq("rd_web", arr_web0, 1);
    check_eq("rd_addr", arr_addr0, a);
    check_eq("rd_data", rd_data, ref_mem[a]);
    check_eq("idle_busy", busy, 0);
    check_eq("idle_done", flush_done, 0);
  endtask

  task automatic read_all();
    for (int j = 0; j < num_sets; j++) idle_read(4'(j));
  endtask

  // Flush with the expected writeback order and sweep length taken from ref_mem.
  // fixed_d < 0 picks a random ack delay per writeback.
  task automatic run_flush(input bit with_wr, input logic [3:0] waddr,
                           input logic [1:0] wdata, input int fixed_d);
    int exp_q[$];
    int k;
    int extra;
    int wait_cnt;
    int d;
    int cur_set;
    bit done_seen;
    @(negedge clk);
    flush_req = 1'b1;
    wb_ack    = 1'b0;
    wr_valid  = with_wr;
    wr_addr   = waddr;
    wr_din    = wdata;
    #1;
    check_eq("flush_start_ready", wr_ready, 1);
    check_eq("flush_start_busy", busy, 0);
    if (with_wr) ref_mem[waddr] = wdata;
    for (int j = 0; j < num_sets; j++) begin
      if (ref_mem[j][0] && ref_mem[j][1]) exp_q.push_back(j);
    end
    k = 0; extra = 0; wait_cnt = 0; d = 0; cur_set = -1; done_seen = 1'b0;
    while (!done_seen && k < 600) begin
      @(negedge clk);
      k++;
      wb_ack    = 1'b0;
      flush_req = 1'($urandom);
      wr_valid  = 1'($urandom);
      wr_addr   = 4'($urandom);
      wr_din    = 2'($urandom);
      rd_addr   = 4'($urandom);
      #1;
      check_eq("sweep_busy", busy, 1);
      check_eq("sweep_wr_ready", wr_ready, 0);
      check_eq("sweep_rd_ok", rd_ok, 0);
      if (wb_req) begin
        check_eq("wb_csb", arr_csb0, 1);
        if (wait_cnt == 0) begin
          if (exp_q.size() == 0) begin
            check_eq("wb_req_unexpected", wb_req, 0);
            cur_set = -1;
          end else begin
            cur_set = exp_q.pop_front();
            check_eq("wb_set", wb_set, cur_set);
          end
          d = (fixed_d >= 0) ? fixed_d : int'($urandom_range(0, 4));
        end else if (cur_set >= 0) begin
          check_eq("wb_set_stable", wb_set, cur_set);
        end
        if (wait_cnt == d) begin
          wb_ack   = 1'b1;
          extra   += d + 1;
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        // Stray acks outside a writeback must have no effect.
        wb_ack = ($urandom_range(0, 3) == 0);
      end
      if (flush_done) begin
        done_seen = 1'b1;
        check_eq("done_cycle", k, 2 * num_sets + 1 + extra);
      end
    end
    check_eq("flush_completed", done_seen, 1);
    check_eq("wb_missing", exp_q.size(), 0);
    for (int j = 0; j < num_sets; j++) ref_mem[j] = 2'b00;
    @(negedge clk);
    flush_req = 1'b0;
    wr_valid  = 1'b0;
    wb_ack    = 1'b0;
    #1;
    check_eq("post_busy", busy, 0);
    check_eq("post_done_pulse", flush_done, 0);
    check_eq("post_wr_ready", wr_ready, 1);
  endtask

  // Reset while a writeback is pending abandons the sweep.
  task automatic reset_mid();
    int s;
    int k;
    s = int'($urandom_range(3, 12));
    for (int j = 0; j < num_sets; j++) begin
      if (j == s)     idle_write(4'(j), 2'b11);
      else if (j < s) idle_write(4'(j), 2'($urandom_range(0, 2)));
      else            idle_write(4'(j), 2'($urandom));
    end
    @(negedge clk);
    flush_req = 1'b1;
    wr_valid  = 1'b0;
    wb_ack    = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      flush_req = 1'b0;
      #1;
      k++;
    end while (!wb_req && k < 100);
    check_eq("rst_wb_seen", wb_req, 1);
    check_eq("rst_wb_set", wb_set, s);
    @(negedge clk);
    rst0     = 1'b1;
    wr_valid = 1'b1;
    wr_addr  = 4'(s);
    wr_din   = 2'b00;
    #1;
    check_eq("rst_in_wb_req", wb_req, 0);
    check_eq("rst_in_busy", busy, 0);
    check_eq("rst_in_csb", arr_csb0, 1);
    check_eq("rst_in_web", arr_web0, 1);
    check_eq("rst_in_wr_ready", wr_ready, 0);
    @(negedge clk);
    rst0     = 1'b0;
    wr_valid = 1'b0;
    #1;
    check_eq("rst_out_busy", busy, 0);
    check_eq("rst_out_wb_req", wb_req, 0);
    check_eq("rst_out_wr_ready", wr_ready, 1);
    check_eq("rst_out_done", flush_done, 0);
    for (int j = 0; j < s; j++) ref_mem[j] = 2'b00;
    read_all();
  endtask

  initial begin
    rst0      = 1'b1;
    rd_addr   = '0;
    wr_valid  = 1'b1;
    wr_addr   = 4'd1;
    wr_din    = 2'b11;
    flush_req = 1'b1;
    wb_ack    = 1'b0;

    repeat (2) @(negedge clk);
    #1;
    check_eq("reset_busy", busy, 0);
    check_eq("reset_done", flush_done, 0);
    check_eq("reset_wb_req", wb_req, 0);
    check_eq("reset_wb_set", wb_set, 0);
    check_eq("reset_csb", arr_csb0, 1);
    check_eq("reset_web", arr_web0, 1);
    check_eq("reset_wr_ready", wr_ready, 0);
    check_eq("reset_rd_ok", rd_ok, 0);

    @(negedge clk);
    rst0      = 1'b0;
    wr_valid  = 1'b0;
    flush_req = 1'b0;
    rd_addr   = 4'd3;
    #1;
    check_eq("t1_addr", arr_addr0, 3);
    check_eq("t1_csb", arr_csb0, 0);
    check_eq("t1_web", arr_web0, 1);
    check_eq("t1_rd_ok", rd_ok, 1);
    check_eq("t1_busy", busy, 0);

    for (int j = 0; j < num_sets; j++) idle_write(4'(j), 2'b00);
    idle_write(4'd5, 2'b11);
    idle_read(4'd5);
    idle_write(4'd5, 2'b00);

    run_flush(1'b0, 4'd0, 2'b00, 0);
    read_all();

    idle_write(4'd2, 2'b11);
    idle_write(4'd9, 2'b11);
    run_flush(1'b0, 4'd0, 2'b00, 3);
    read_all();

    run_flush(1'b1, 4'd7, 2'b11, -1);
    read_all();

    for (int r = 0; r < 4; r++) begin
      for (int j = 0; j < num_sets; j++) idle_write(4'(j), 2'($urandom));
      run_flush(1'($urandom), 4'($urandom), 2'($urandom), -1);
      read_all();
    end

    reset_mid();

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 1) == 1) idle_write(4'($urandom), 2'($urandom));
      else                           idle_read(4'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
